// File: rtl/drive_phase_gen.sv
// Drive-CPU phase-2 strobe generator: parametrised divider off the system ce,
// with 1x/2x speed, cycle-boundary pause, single-step and a drive-cycle counter.
module drive_phase_gen #(
    parameter int DIV_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             speed_2x,
    input  logic             pause,
    input  logic             step,
    output logic             p2_h_r,
    output logic             p2_h_f,
    output logic             paused,
    output logic             mode_2x,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam logic [DIV_W-1:0] PH_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] PH_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] PH_TWO  = {{(DIV_W-2){1'b0}}, 2'b10};
    localparam logic [DIV_W-1:0] PH_HALF = {1'b1, {(DIV_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] ph_q, ph_d;
    logic             p2r_q, p2r_d;
    logic             p2f_q, p2f_d;
    logic             paused_q, paused_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pause_q, pause_d;
    logic             step_pend_q, step_pend_d;
    logic             hold_s;

    // A boundary holds unless an outstanding step releases an already-paused generator.
    assign hold_s = pause_q && !(paused_q && step_pend_q);

    // Next-state logic: only ce ticks move the phase; strobes default to 0.
    always_comb begin
        ph_d        = ph_q;
        p2r_d       = 1'b0;
        p2f_d       = 1'b0;
        paused_d    = paused_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        pause_d     = pause;
        step_pend_d = step_pend_q | step;
        if (ce) begin
            if (ph_q == PH_ZERO) begin
                // The new speed takes effect on this very advance, keeping ph even in 2x.
                mode_d = speed_2x;
                if (hold_s) begin
                    paused_d = 1'b1;
                    if (!paused_q) begin
                        step_pend_d = 1'b0;
                    end else begin
                        step_pend_d = step_pend_q | step;
                    end
                end else begin
                    paused_d    = 1'b0;
                    p2r_d       = 1'b1;
                    ph_d        = ph_q + (speed_2x ? PH_TWO : PH_ONE);
                    step_pend_d = 1'b0;
                end
            end else begin
                ph_d = ph_q + (mode_q ? PH_TWO : PH_ONE);
                if (ph_q == PH_HALF) begin
                    p2f_d = 1'b1;
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    p2f_d = 1'b0;
                    cnt_d = cnt_q;
                end
            end
        end else begin
            ph_d = ph_q;
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph_q        <= PH_ZERO;
            p2r_q       <= 1'b0;
            p2f_q       <= 1'b0;
            paused_q    <= 1'b0;
            mode_q      <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            pause_q     <= 1'b0;
            step_pend_q <= 1'b0;
        end else begin
            ph_q        <= ph_d;
            p2r_q       <= p2r_d;
            p2f_q       <= p2f_d;
            paused_q    <= paused_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            pause_q     <= pause_d;
            step_pend_q <= step_pend_d;
        end
    end

    assign p2_h_r    = p2r_q;
    assign p2_h_f    = p2f_q;
    assign paused    = paused_q;
    assign mode_2x   = mode_q;
    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_drive_phase_gen.sv
// Directed bench for drive_phase_gen: steady-state vector table plus hand-written
// sequences for speed change, pause/step/resume, mid-cycle reset and counter wrap.
module tb_drive_phase_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic        speed_2x = 1'b0;
    logic        pause = 1'b0;
    logic        step = 1'b0;
    logic        p2_h_r, p2_h_f, paused, mode_2x;
    logic [31:0] cycle_cnt;
    logic        r4, f4, paused4, mode4;
    logic [3:0]  cnt4;

    drive_phase_gen #(.DIV_W(4), .CNT_W(32)) dut (
        .clk(clk), .reset(rst), .ce(ce), .speed_2x(speed_2x), .pause(pause), .step(step),
        .p2_h_r(p2_h_r), .p2_h_f(p2_h_f), .paused(paused), .mode_2x(mode_2x),
        .cycle_cnt(cycle_cnt)
    );

    drive_phase_gen #(.DIV_W(4), .CNT_W(4)) dut_w4 (
        .clk(clk), .reset(rst), .ce(ce), .speed_2x(speed_2x), .pause(pause), .step(step),
        .p2_h_r(r4), .p2_h_f(f4), .paused(paused4), .mode_2x(mode4),
        .cycle_cnt(cnt4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   ce_div;
        logic spd;
        int   n_clk;
        int   exp_r;
        int   exp_f;
        int   exp_cnt;
        logic exp_mode;
        int   exp_r2_clk;
    } vec_t;

    vec_t tbl[5];
    int   r_q[$];
    int   f_q[$];
    int   clk_i, wide, mode_first, paused_first, paused_fall, paused_rise_last;
    logic prev_r, prev_f, prev_p;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int r_at(input int i);
        if (i < r_q.size()) return r_q[i];
        else return -1;
    endfunction

    function automatic int f_at(input int i);
        if (i < f_q.size()) return f_q[i];
        else return -1;
    endfunction

    task automatic clear_bk();
        r_q.delete();
        f_q.delete();
        clk_i = 0; wide = 0;
        mode_first = -1; paused_first = -1; paused_fall = -1; paused_rise_last = -1;
        prev_r = 1'b0; prev_f = 1'b0; prev_p = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_bk();
    endtask

    // Clock index k is the k-th posedge after reset release; ce is high on every div-th one.
    task automatic run_clks(input int n, input int div);
        for (int k = 0; k < n; k++) begin
            ce = ((clk_i % div) == 0);
            @(posedge clk);
            #1;
            if (p2_h_r) r_q.push_back(clk_i);
            if (p2_h_f) f_q.push_back(clk_i);
            if ((p2_h_r && prev_r) || (p2_h_f && prev_f)) wide++;
            if (mode_2x && mode_first < 0) mode_first = clk_i;
            if (paused && !prev_p) begin
                paused_rise_last = clk_i;
                if (paused_first < 0) paused_first = clk_i;
            end
            if (!paused && prev_p) paused_fall = clk_i;
            prev_r = p2_h_r; prev_f = p2_h_f; prev_p = paused;
            clk_i++;
        end
    endtask

    initial begin
        tbl[0] = '{ce_div: 1, spd: 1'b0, n_clk: 33,  exp_r: 3, exp_f: 2, exp_cnt: 2, exp_mode: 1'b0, exp_r2_clk: 16};
        tbl[1] = '{ce_div: 1, spd: 1'b1, n_clk: 33,  exp_r: 5, exp_f: 4, exp_cnt: 4, exp_mode: 1'b1, exp_r2_clk: 8};
        tbl[2] = '{ce_div: 3, spd: 1'b0, n_clk: 100, exp_r: 3, exp_f: 2, exp_cnt: 2, exp_mode: 1'b0, exp_r2_clk: 48};
        tbl[3] = '{ce_div: 2, spd: 1'b1, n_clk: 40,  exp_r: 3, exp_f: 2, exp_cnt: 2, exp_mode: 1'b1, exp_r2_clk: 16};
        tbl[4] = '{ce_div: 4, spd: 1'b1, n_clk: 40,  exp_r: 2, exp_f: 1, exp_cnt: 1, exp_mode: 1'b1, exp_r2_clk: 32};

        #2 rst = 1'b1;
        #1;
        chk("rst_p2_h_r", p2_h_r, 0);
        chk("rst_p2_h_f", p2_h_f, 0);
        chk("rst_paused", paused, 0);
        chk("rst_mode_2x", mode_2x, 0);
        chk("rst_cycle_cnt", cycle_cnt, 0);

        // Steady-state runs from reset.
        for (int i = 0; i < 5; i++) begin
            speed_2x = tbl[i].spd;
            do_reset();
            run_clks(tbl[i].n_clk, tbl[i].ce_div);
            chk($sformatf("row%0d_n_rise", i), r_q.size(), tbl[i].exp_r);
            chk($sformatf("row%0d_n_fall", i), f_q.size(), tbl[i].exp_f);
            chk($sformatf("row%0d_cnt", i), cycle_cnt, tbl[i].exp_cnt);
            chk($sformatf("row%0d_mode", i), mode_2x, tbl[i].exp_mode);
            chk($sformatf("row%0d_rise0_clk", i), r_at(0), 0);
            chk($sformatf("row%0d_rise1_clk", i), r_at(1), tbl[i].exp_r2_clk);
            chk($sformatf("row%0d_wide", i), wide, 0);
        end

        // speed_2x raised mid-cycle only takes effect at the next boundary.
        speed_2x = 1'b0;
        do_reset();
        run_clks(5, 1);
        speed_2x = 1'b1;
        run_clks(28, 1);
        chk("spd_n_rise", r_q.size(), 4);
        chk("spd_rise1", r_at(1), 16);
        chk("spd_rise2", r_at(2), 24);
        chk("spd_rise3", r_at(3), 32);
        chk("spd_n_fall", f_q.size(), 3);
        chk("spd_fall0", f_at(0), 8);
        chk("spd_fall1", f_at(1), 20);
        chk("spd_fall2", f_at(2), 28);
        chk("spd_mode_rise", mode_first, 16);
        chk("spd_cnt", cycle_cnt, 3);

        // Pause mid-cycle, single step, then resume.
        speed_2x = 1'b0;
        do_reset();
        run_clks(3, 1);
        pause = 1'b1;
        run_clks(38, 1);
        chk("pause_n_rise", r_q.size(), 1);
        chk("pause_fall0", f_at(0), 8);
        chk("pause_first", paused_first, 16);
        chk("pause_cnt", cycle_cnt, 1);
        step = 1'b1;
        run_clks(1, 1);
        step = 1'b0;
        run_clks(29, 1);
        chk("step_n_rise", r_q.size(), 2);
        chk("step_rise", r_at(1), 42);
        chk("step_n_fall", f_q.size(), 2);
        chk("step_fall", f_at(1), 50);
        chk("step_cnt", cycle_cnt, 2);
        chk("step_unpause", paused_fall, 42);
        chk("step_repause", paused_rise_last, 58);
        chk("step_paused_end", paused, 1);
        pause = 1'b0;
        run_clks(3, 1);
        chk("resume_rise", r_at(2), 72);
        chk("resume_paused", paused, 0);

        // Pause and step together while running: the pause wins, no extra cycle.
        do_reset();
        run_clks(3, 1);
        pause = 1'b1;
        step = 1'b1;
        run_clks(1, 1);
        step = 1'b0;
        run_clks(37, 1);
        chk("pstep_n_rise", r_q.size(), 1);
        chk("pstep_cnt", cycle_cnt, 1);
        chk("pstep_paused", paused, 1);
        pause = 1'b0;

        // Asynchronous reset mid-cycle in 2x mode.
        speed_2x = 1'b1;
        do_reset();
        run_clks(10, 1);
        chk("mrst_pre_cnt", cycle_cnt, 1);
        chk("mrst_pre_mode", mode_2x, 1);
        rst = 1'b1;
        #1;
        chk("mrst_cnt", cycle_cnt, 0);
        chk("mrst_mode", mode_2x, 0);
        chk("mrst_rise", p2_h_r, 0);
        @(posedge clk);
        #1;
        chk("mrst_hold_cnt", cycle_cnt, 0);
        chk("mrst_hold_rise", p2_h_r, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_bk();
        run_clks(1, 1);
        chk("mrst_first_rise", r_at(0), 0);

        // Counter wrap on the narrow instance after 17 cycles.
        speed_2x = 1'b0;
        do_reset();
        run_clks(271, 1);
        chk("wrap_cnt32", cycle_cnt, 17);
        chk("wrap_cnt4", cnt4, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
